// File: rtl/async_receiver_pkg.sv
// rtl/async_receiver_pkg.sv - shared UART frame constants, FSM states and divider helper
package async_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Rounded clock divider for one oversample tick.
  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + baud * os / 2) / (baud * os);
  endfunction

  // Odd-parity bit the transmitter appends to a data byte.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/async_receiver_uart_baud_tick.sv
// rtl/async_receiver_uart_baud_tick.sv - free-running tick divider with synchronous phase restart
module uart_baud_tick #(
  parameter int DIV = 326
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A restart wins over a coincident wrap, so no tick escapes on the restart cycle.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + 1'b1;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/async_receiver.sv
// rtl/async_receiver.sv - UART receiver: 8 data bits LSB first, odd parity, 1 stop bit
module async_receiver
  import async_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 19200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_parity_err,
  output logic       RxD_frame_err,
  output logic       RxD_busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

  logic [1:0]     sync_q, sync_d;
  logic           rxs_prev_q, rxs_prev_d;
  rx_state_e      state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic [7:0]     data_q, data_d;
  logic           ready_q, ready_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           busy_q, busy_d;

  logic rxs, fall, restart, tick, mid_bit;

  assign rxs     = sync_q[1];
  assign fall    = rxs_prev_q & ~rxs;
  assign restart = (state_q == ST_IDLE) && fall;
  assign mid_bit = tick && (sc_q == SC_LAST);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    sync_d     = {sync_q[0], RxD};
    rxs_prev_d = rxs;
    state_d    = state_q;
    sc_d       = sc_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    // After the start check, sc counts a full bit so every sample lands mid-bit.
    if (tick && (state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP)) begin
      sc_d = mid_bit ? '0 : sc_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          sc_d    = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sc_q == SC_HALF) begin
            if (rxs) begin
              state_d = ST_IDLE;
            end else begin
              sc_d    = '0;
              idx_d   = '0;
              state_d = ST_DATA;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (mid_bit) begin
          shreg_d[idx_q] = rxs;
          if (idx_q == IDX_LAST) state_d = ST_PARITY;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (mid_bit) begin
          par_d   = rxs;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid_bit) begin
          data_d  = shreg_q;
          perr_d  = par_q ^ odd_parity(shreg_q);
          ferr_d  = ~rxs;
          ready_d = 1'b1;
          state_d = rxs ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      sc_q       <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      sc_q       <= sc_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign RxD_parity_err = perr_q;
  assign RxD_frame_err  = ferr_q;
  assign RxD_busy       = busy_q;

endmodule

// File: tb/tb_async_receiver.sv
// tb/tb_async_receiver.sv - directed bench for async_receiver at a scaled 160 clk/bit rate
module tb_async_receiver;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int BIT      = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_parity_err;
  logic       RxD_frame_err;
  logic       RxD_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_cyc = 0;
  int ready_cnt = 0;
  logic [7:0] got [64];

  async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .RxD            (RxD),
    .RxD_data       (RxD_data),
    .RxD_data_ready (RxD_data_ready),
    .RxD_parity_err (RxD_parity_err),
    .RxD_frame_err  (RxD_frame_err),
    .RxD_busy       (RxD_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RxD_data_ready) begin
      got[ready_cnt % 64] = RxD_data;
      ready_cnt = ready_cnt + 1;
      ready_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bt);
    @(negedge clk);
    RxD = 1'b0;
    start_cyc = cyc;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (bt) @(negedge clk);
    end
    RxD = par;
    repeat (bt) @(negedge clk);
    RxD = stp;
    repeat (bt) @(negedge clk);
  endtask

  task automatic chk_frame(input string tag, input int cnt, input logic [7:0] d,
                           input logic perr, input logic ferr);
    chk({tag, "_cnt"},  32'(ready_cnt), 32'(cnt));
    chk({tag, "_data"}, 32'(RxD_data), 32'(d));
    chk({tag, "_perr"}, 32'(RxD_parity_err), 32'(perr));
    chk({tag, "_ferr"}, 32'(RxD_frame_err), 32'(ferr));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(RxD_data), 32'h00);
    chk("rst_ready", 32'(RxD_data_ready), 32'h0);
    chk("rst_perr",  32'(RxD_parity_err), 32'h0);
    chk("rst_ferr",  32'(RxD_frame_err), 32'h0);
    chk("rst_busy",  32'(RxD_busy), 32'h0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_busy", 32'(RxD_busy), 32'h0);
    chk("idle_cnt",  32'(ready_cnt), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b1, BIT);
    chk_frame("good_a5", 1, 8'hA5, 1'b0, 1'b0);
    chk("good_latency", 32'(ready_cyc - start_cyc), 32'd1683);
    chk("good_busy", 32'(RxD_busy), 32'h0);

    send_frame(8'h01, 1'b1, 1'b1, BIT);
    chk_frame("badpar_01", 2, 8'h01, 1'b1, 1'b0);

    @(negedge clk);
    RxD = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy_hi", 32'(RxD_busy), 32'h1);
    repeat (20) @(negedge clk);
    RxD = 1'b1;
    repeat (80) @(negedge clk);
    chk("glitch_busy_lo", 32'(RxD_busy), 32'h0);
    chk("glitch_cnt", 32'(ready_cnt), 32'd2);
    send_frame(8'h3C, 1'b1, 1'b1, BIT);
    chk_frame("after_glitch_3c", 3, 8'h3C, 1'b0, 1'b0);

    send_frame(8'hFF, 1'b1, 1'b0, BIT);
    repeat (3 * BIT) @(negedge clk);
    chk_frame("frame_ff", 4, 8'hFF, 1'b0, 1'b1);
    chk("frame_busy_wait", 32'(RxD_busy), 32'h1);
    RxD = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("frame_cnt_hold", 32'(ready_cnt), 32'd4);
    chk("frame_busy_lo", 32'(RxD_busy), 32'h0);
    send_frame(8'h42, 1'b1, 1'b1, BIT);
    chk_frame("after_frame_42", 5, 8'h42, 1'b0, 1'b0);

    @(negedge clk);
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = (8'h5A >> i) & 8'h01;
      repeat (BIT) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    chk("midrst_busy_pre", 32'(RxD_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data",  32'(RxD_data), 32'h00);
    chk("midrst_ready", 32'(RxD_data_ready), 32'h0);
    chk("midrst_perr",  32'(RxD_parity_err), 32'h0);
    chk("midrst_ferr",  32'(RxD_frame_err), 32'h0);
    chk("midrst_busy",  32'(RxD_busy), 32'h0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("midrst_cnt", 32'(ready_cnt), 32'd5);
    send_frame(8'h96, 1'b1, 1'b1, BIT);
    chk_frame("after_rst_96", 6, 8'h96, 1'b0, 1'b0);

    send_frame(8'h80, 1'b0, 1'b1, BIT);
    send_frame(8'h7E, 1'b1, 1'b1, BIT);
    chk_frame("b2b_7e", 8, 8'h7E, 1'b0, 1'b0);
    chk("b2b_first", 32'(got[6]), 32'h80);

    send_frame(8'h3A, 1'b1, 1'b1, 157);
    send_frame(8'hC5, 1'b1, 1'b1, 157);
    chk("fast_first", 32'(got[8]), 32'h3A);
    chk_frame("fast_c5", 10, 8'hC5, 1'b0, 1'b0);
    send_frame(8'h69, 1'b1, 1'b1, 163);
    send_frame(8'h0F, 1'b1, 1'b1, 163);
    chk("slow_first", 32'(got[10]), 32'h69);
    chk_frame("slow_0f", 12, 8'h0F, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
